// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-requester arbiter for a single-port synchronous RAM.
//            It uses a 3-cycle IDLE/ACCESS/DONE handshake per transaction.
//            Ties are resolved round-robin. When MEM_ARB_FIXED_PRIO_EN is
//            defined, requester A always wins a tie.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              reqA,
  input  logic              weA,
  input  logic [ADDR_W-1:0] addrA,
  input  logic [DATA_W-1:0] wdataA,
  output logic              ackA,
  output logic [DATA_W-1:0] rdataA,
  input  logic              reqB,
  input  logic              weB,
  input  logic [ADDR_W-1:0] addrB,
  input  logic [DATA_W-1:0] wdataB,
  output logic              ackB,
  output logic [DATA_W-1:0] rdataB,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  output logic              memWe,
  input  logic [DATA_W-1:0] memRData,
  output logic              busy,
  output logic              lastGrant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state;
  logic              grant;      // 0 = A, 1 = B for the transaction in flight
  logic              grant_we;
  logic              last_grant;
  logic              ack_a_q;
  logic              ack_b_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] rdata_a_q;
  logic [DATA_W-1:0] rdata_b_q;
  logic              next_grant;

  always_comb begin
    next_grant = last_grant;
    if (reqA && reqB) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      next_grant = 1'b0;
`else
      next_grant = ~last_grant;
`endif
    end else if (reqA) begin
      next_grant = 1'b0;
    end else if (reqB) begin
      next_grant = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= 1'b0;
      grant_we    <= 1'b0;
      last_grant  <= 1'b1;
      ack_a_q     <= 1'b0;
      ack_b_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_a_q   <= '0;
      rdata_b_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (reqA || reqB) begin
            state       <= ACCESS;
            grant       <= next_grant;
            last_grant  <= next_grant;
            grant_we    <= next_grant ? weB : weA;
            mem_we_q    <= next_grant ? weB : weA;
            mem_addr_q  <= next_grant ? addrB : addrA;
            mem_wdata_q <= next_grant ? wdataB : wdataA;
          end
        end
        ACCESS: begin
          state       <= DONE;
          mem_we_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          ack_a_q     <= ~grant;
          ack_b_q     <= grant;
        end
        DONE: begin
          state   <= IDLE;
          ack_a_q <= 1'b0;
          ack_b_q <= 1'b0;
          if (!grant_we) begin
            if (grant) rdata_b_q <= memRData;
            else       rdata_a_q <= memRData;
          end
        end
        default: begin
          state       <= IDLE;
          ack_a_q     <= 1'b0;
          ack_b_q     <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
        end
      endcase
    end
  end

  // RAM data is forwarded during DONE and is then held by the per-requester register.
  assign rdataA    = (state == DONE && !grant && !grant_we) ? memRData : rdata_a_q;
  assign rdataB    = (state == DONE &&  grant && !grant_we) ? memRData : rdata_b_q;
  assign ackA      = ack_a_q;
  assign ackB      = ack_b_q;
  assign memWe     = mem_we_q;
  assign memAddr   = mem_addr_q;
  assign memWData  = mem_wdata_q;
  assign busy      = (state != IDLE);
  assign lastGrant = last_grant;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16: width of every address bus.
REQ-002 Parameter DATA_W, default 16: width of every data bus.
REQ-003 clock  in  1  single clock; all state updates on posedge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 reqA  in  1  requester A (CPU fetch/load/store) transaction request; held high until ackA.
REQ-006 weA  in  1  requester A write (1) / read (0); stable while reqA high.
REQ-007 addrA  in  ADDR_W  requester A address; stable while reqA high.
REQ-008 wdataA  in  DATA_W  requester A write data; stable while reqA high.
REQ-009 ackA  out  1  one-cycle completion pulse to A.
REQ-010 rdataA  out  DATA_W  read data returned to A.
REQ-011 reqB, weB, addrB, wdataB, ackB, rdataB: requester B (peripheral/display port); same directions, widths and meanings as the A ports.
REQ-012 memAddr  out  ADDR_W  shared single-port synchronous RAM address.
REQ-013 memWData  out  DATA_W  RAM write data.
REQ-014 memWe  out  1  RAM write enable.
REQ-015 memRData  in  DATA_W  RAM read data; valid one cycle after address presented.
REQ-016 busy  out  1  high when the state is not IDLE.
REQ-017 lastGrant  out  1  0 = A, 1 = B; requester served by the most recent grant.

Function
REQ-018 FSM states: IDLE, ACCESS, DONE; each transaction is exactly 3 cycles, IDLE -> ACCESS -> DONE -> IDLE.
REQ-019 IDLE: with reqA or reqB high, latch grantee and go to ACCESS; with neither high, stay in IDLE.
REQ-020 Tie (both requests high in IDLE): grant the requester that is not lastGrant (round-robin).
REQ-021 Single request: grant that requester regardless of lastGrant.
REQ-022 lastGrant updates on the IDLE->ACCESS edge.
REQ-023 ACCESS: memAddr = grantee address; memWData = grantee wdata; memWe = grantee we.
REQ-024 Outside ACCESS: memAddr = 0, memWData = 0, memWe = 0.
REQ-025 DONE: ack of grantee = 1 for exactly one cycle; other ack = 0; acks are 0 in all other states.
REQ-026 Read: rdata of grantee = memRData during DONE; register captured at DONE exit; holds until that requester's next completed read.
REQ-027 Write: ack pulses in DONE; rdata of grantee unchanged.
REQ-028 Request changes while not granted have no effect; requester drops req on the edge ending its ack cycle; req still high in the next IDLE is a new transaction.
REQ-029 Non-grantee rdata and ack are unaffected by another requester's transaction.

Reset
REQ-030 Asynchronous on reset high: state = IDLE, ackA = ackB = 0, memWe = 0, memAddr = memWData = 0, rdataA = rdataB = 0, lastGrant = 1 (A wins the first tie), busy = 0.
REQ-031 Reset asserted mid-transaction aborts it: no ack issued, no memWe thereafter; operation resumes from IDLE after deassertion.

Configuration
REQ-032 Macro MEM_ARB_FIXED_PRIO_EN defined: ties always grant A; lastGrant still reports the grantee.
REQ-033 MEM_ARB_FIXED_PRIO_EN undefined: round-robin tie rule of REQ-020.

Verification
REQ-034 A write addr 0x0010 data 0xBEEF, then A read 0x0010 -> memWe high 1 cycle; second ackA cycle rdataA = 0xBEEF; each transaction 3 cycles.
REQ-035 reqA and reqB both held from reset release, both reads -> grant order A, B, A, B (round-robin); with MEM_ARB_FIXED_PRIO_EN, A continuously while reqA held.
REQ-036 Only reqB high, lastGrant = 1 -> B granted immediately; ackB on cycle 3; ackA stays 0.
REQ-037 B read 0x0004 (RAM 0x1234), then A write -> rdataB holds 0x1234 through A's transaction.
REQ-038 Reset pulsed during ACCESS of an A write -> no ackA, memWe 0 from reset assertion, state IDLE, rdataA = 0, lastGrant = 1.
REQ-039 No requests for 20 cycles -> busy = 0, memWe = 0, memAddr = 0 throughout.
